sequenciador_entrada: RTL and testbench
=======================================

// Module: sequenciador_entrada
// PURPOSE
//   Input sequencer for the ULA. Debounces the raw entry button and steps an FSM
//   that captures operand A, operand B and the op code, then launches the ULA.
//   It waits for the ULA result (with timeout) and holds the result state until
//   the user acknowledges it.
//   Drives the 2-bit contador_entrada code (00=A, 01=B, 10=op, 11=exec) consumed
//   by the entry-enable decoder, and presents registered operands to the ULA.
// PARAMETERS
//   LARGURA          8   operand width
//   DEBOUNCE_CICLOS  4   consecutive stable synced samples needed to change filtered button level
//   TIMEOUT_ULA      16  max cycles waited for ula_pronto after executar_operacao
// PORTS
//   clk                in   1        single system clock, rising edge
//   rst_n              in   1        reset, asynchronous, active-low
//   entrada_botao      in   1        raw button, asynchronous, active-high, bouncy
//   entrada_numero     in   LARGURA  operand value from switches
//   operacao           in   3        op code from switches
//   ula_pronto         in   1        ULA result valid (sampled only in S_AGUARDA)
//   contador_entrada   out  2        entry phase code to enable decoder
//   numero_a           out  LARGURA  captured operand A
//   numero_b           out  LARGURA  captured operand B
//   codigo_op          out  3        captured op code
//   executar_operacao  out  1        one-cycle ULA start pulse
//   ocupado            out  1        high while the ULA operation is in flight
//   resultado_valido   out  1        ULA finished; held until acknowledged
//   erro_timeout       out  1        ULA did not answer in time; held until acknowledged
// BEHAVIOUR
//   Reset (async assert, sync release):
//   - all outputs 0, FSM=S_A, filtered level 0, all counters 0.
//   - Mid-operation reset aborts immediately; no executar pulse is emitted.
//   Button path: 2-FF synchronizer -> debounce counter -> filtered level.
//   - Counter resets whenever synced sample equals filtered level.
//   - Filtered level flips when the counter reaches DEBOUNCE_CICLOS.
//   - pressao = 1-cycle pulse on filtered rising edge; latency raw->pressao = 2+DEBOUNCE_CICLOS cycles.
//   - Button held through reset release yields one pressao after debounce.
//   FSM (all outputs registered; contador_entrada in brackets):
//   - S_A [00]: pressao -> numero_a<=entrada_numero, go S_B.
//   - S_B [01]: pressao -> numero_b<=entrada_numero, go S_OP.
//   - S_OP [10]: pressao -> codigo_op<=operacao, go S_EXEC.
//   - S_EXEC [11]: pressao -> next cycle executar_operacao=1 and ocupado=1, go S_AGUARDA, timer cleared.
//   - S_AGUARDA [11]: ocupado=1; timer increments each cycle.
//     - ula_pronto=1 -> resultado_valido<=1, ocupado<=0, go S_MOSTRA.
//     - timer==TIMEOUT_ULA without ula_pronto -> erro_timeout<=1, ocupado<=0, go S_MOSTRA.
//     - ula_pronto in the terminal-count cycle wins (valid=1, erro=0).
//     - pressao ignored.
//   - S_MOSTRA [11]: flags held; pressao -> clear both flags, go S_A.
//   - Captured registers keep their values until overwritten in the next pass.
//   Pulse and sampling rules:
//   - executar_operacao is high exactly 1 cycle per pass; never in any other state.
//   - ula_pronto outside S_AGUARDA is ignored.
//   - Timer width = $clog2(TIMEOUT_ULA+1); no wrap (frozen once FSM leaves S_AGUARDA).
//   - Input captures happen on the pressao cycle; values on the inputs at other times are don't-care.
// TESTING (DEBOUNCE_CICLOS=4, TIMEOUT_ULA=16)
//   1. Assert rst_n=0 -> all outputs 0, contador_entrada=00; release, no button -> no change.
//   2. Presses with entrada_numero=8'h2A, then 8'h15, operacao=3'b001, 4th press ->
//      numero_a=2A, numero_b=15, codigo_op=001; contador 00->01->10->11; one executar pulse;
//      ula_pronto 3 cycles later -> resultado_valido=1; 5th press -> contador=00, valid=0.
//   3. Button toggling every cycle for 6 cycles then stable high 6 cycles -> exactly one pressao;
//      isolated 3-cycle high glitch -> no pressao, contador unchanged.
//   4. No ula_pronto -> erro_timeout=1 and ocupado=0 exactly 16 cycles after executar;
//      resultado_valido=0; ula_pronto at terminal cycle -> valid=1, erro=0.
//   5. Presses during S_AGUARDA -> ignored (no 2nd executar, contador stays 11).
//   6. rst_n=0 while in S_AGUARDA -> same-cycle contador_entrada=00, ocupado=0;
//      later ula_pronto -> ignored.

Source files
------------

// File: rtl/sequenciador_entrada.sv
// Entry sequencer for the ULA: debounces the entry button, captures A, B and the
// op code on successive presses, launches the ULA and holds its outcome until acknowledged.
module sequenciador_entrada #(
    parameter int LARGURA         = 8,
    parameter int DEBOUNCE_CICLOS = 4,
    parameter int TIMEOUT_ULA     = 16
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               entrada_botao,
    input  logic [LARGURA-1:0] entrada_numero,
    input  logic [2:0]         operacao,
    input  logic               ula_pronto,
    output logic [1:0]         contador_entrada,
    output logic [LARGURA-1:0] numero_a,
    output logic [LARGURA-1:0] numero_b,
    output logic [2:0]         codigo_op,
    output logic               executar_operacao,
    output logic               ocupado,
    output logic               resultado_valido,
    output logic               erro_timeout
);

    localparam int TW = $clog2(TIMEOUT_ULA + 1);
    localparam int DW = $clog2(DEBOUNCE_CICLOS + 1);

    typedef enum logic [2:0] {
        S_A       = 3'd0,
        S_B       = 3'd1,
        S_OP      = 3'd2,
        S_EXEC    = 3'd3,
        S_AGUARDA = 3'd4,
        S_MOSTRA  = 3'd5
    } estado_t;

    function automatic logic [1:0] fase_codigo(input estado_t e);
        case (e)
            S_A:     fase_codigo = 2'b00;
            S_B:     fase_codigo = 2'b01;
            S_OP:    fase_codigo = 2'b10;
            default: fase_codigo = 2'b11;
        endcase
    endfunction

    logic          sync1_r, sync2_r, filtrado_r, pressao_r;
    logic [DW-1:0] deb_cnt_r;

    estado_t            estado_r, estado_s;
    logic [1:0]         contador_r, contador_s;
    logic [LARGURA-1:0] numero_a_r, numero_a_s, numero_b_r, numero_b_s;
    logic [2:0]         codigo_op_r, codigo_op_s;
    logic               executar_r, executar_s, ocupado_r, ocupado_s;
    logic               valido_r, valido_s, erro_r, erro_s;
    logic [TW-1:0]      timer_r, timer_s, timer_inc_s;

    // Button synchronizer and debounce filter; pressao marks a filtered rising edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_r    <= 1'b0;
            sync2_r    <= 1'b0;
            filtrado_r <= 1'b0;
            pressao_r  <= 1'b0;
            deb_cnt_r  <= {DW{1'b0}};
        end else begin
            sync1_r <= entrada_botao;
            sync2_r <= sync1_r;
            if (sync2_r == filtrado_r) begin
                deb_cnt_r <= {DW{1'b0}};
                pressao_r <= 1'b0;
            end else if (deb_cnt_r == DW'(DEBOUNCE_CICLOS - 1)) begin
                filtrado_r <= sync2_r;
                deb_cnt_r  <= {DW{1'b0}};
                pressao_r  <= sync2_r;
            end else begin
                deb_cnt_r <= deb_cnt_r + {{(DW-1){1'b0}}, 1'b1};
                pressao_r <= 1'b0;
            end
        end
    end

    assign timer_inc_s = timer_r + {{(TW-1){1'b0}}, 1'b1};

    // Next-state and next-output logic of the entry FSM.
    always_comb begin
        estado_s    = estado_r;
        numero_a_s  = numero_a_r;
        numero_b_s  = numero_b_r;
        codigo_op_s = codigo_op_r;
        executar_s  = 1'b0;
        ocupado_s   = ocupado_r;
        valido_s    = valido_r;
        erro_s      = erro_r;
        timer_s     = timer_r;
        case (estado_r)
            S_A: begin
                if (pressao_r) begin
                    numero_a_s = entrada_numero;
                    estado_s   = S_B;
                end else begin
                    estado_s = S_A;
                end
            end
            S_B: begin
                if (pressao_r) begin
                    numero_b_s = entrada_numero;
                    estado_s   = S_OP;
                end else begin
                    estado_s = S_B;
                end
            end
            S_OP: begin
                if (pressao_r) begin
                    codigo_op_s = operacao;
                    estado_s    = S_EXEC;
                end else begin
                    estado_s = S_OP;
                end
            end
            S_EXEC: begin
                if (pressao_r) begin
                    executar_s = 1'b1;
                    ocupado_s  = 1'b1;
                    timer_s    = {TW{1'b0}};
                    estado_s   = S_AGUARDA;
                end else begin
                    estado_s = S_EXEC;
                end
            end
            S_AGUARDA: begin
                // A result arriving in the terminal-count cycle still counts as success.
                timer_s = timer_inc_s;
                if (ula_pronto) begin
                    valido_s  = 1'b1;
                    ocupado_s = 1'b0;
                    estado_s  = S_MOSTRA;
                end else if (timer_inc_s == TW'(TIMEOUT_ULA)) begin
                    erro_s    = 1'b1;
                    ocupado_s = 1'b0;
                    estado_s  = S_MOSTRA;
                end else begin
                    estado_s = S_AGUARDA;
                end
            end
            S_MOSTRA: begin
                if (pressao_r) begin
                    valido_s = 1'b0;
                    erro_s   = 1'b0;
                    estado_s = S_A;
                end else begin
                    estado_s = S_MOSTRA;
                end
            end
            default: begin
                estado_s  = S_A;
                ocupado_s = 1'b0;
                valido_s  = 1'b0;
                erro_s    = 1'b0;
            end
        endcase
        contador_s = fase_codigo(estado_s);
    end

    // FSM state and registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            estado_r    <= S_A;
            contador_r  <= 2'b00;
            numero_a_r  <= {LARGURA{1'b0}};
            numero_b_r  <= {LARGURA{1'b0}};
            codigo_op_r <= 3'b000;
            executar_r  <= 1'b0;
            ocupado_r   <= 1'b0;
            valido_r    <= 1'b0;
            erro_r      <= 1'b0;
            timer_r     <= {TW{1'b0}};
        end else begin
            estado_r    <= estado_s;
            contador_r  <= contador_s;
            numero_a_r  <= numero_a_s;
            numero_b_r  <= numero_b_s;
            codigo_op_r <= codigo_op_s;
            executar_r  <= executar_s;
            ocupado_r   <= ocupado_s;
            valido_r    <= valido_s;
            erro_r      <= erro_s;
            timer_r     <= timer_s;
        end
    end

    assign contador_entrada  = contador_r;
    assign numero_a          = numero_a_r;
    assign numero_b          = numero_b_r;
    assign codigo_op         = codigo_op_r;
    assign executar_operacao = executar_r;
    assign ocupado           = ocupado_r;
    assign resultado_valido  = valido_r;
    assign erro_timeout      = erro_r;

endmodule

// File: tb/tb_sequenciador_entrada.sv
// Bench for sequenciador_entrada: directed scenarios plus random button/ULA traffic,
// checked every cycle against a window-based debounce and deadline-based timeout model.
module tb_sequenciador_entrada;
    localparam int W   = 8;
    localparam int DEB = 4;
    localparam int TO  = 16;

    logic         clk = 1'b0;
    logic         rst_n = 1'b1;
    logic         botao = 1'b0;
    logic [W-1:0] num = 8'h00;
    logic [2:0]   op = 3'b000;
    logic         pronto = 1'b0;

    logic [1:0]   contador;
    logic [W-1:0] na, nb;
    logic [2:0]   cop;
    logic         exec, ocup, val, err;

    int n_cmp  = 0;
    int n_fail = 0;

    sequenciador_entrada #(.LARGURA(W), .DEBOUNCE_CICLOS(DEB), .TIMEOUT_ULA(TO)) dut (
        .clk(clk), .rst_n(rst_n), .entrada_botao(botao), .entrada_numero(num),
        .operacao(op), .ula_pronto(pronto), .contador_entrada(contador),
        .numero_a(na), .numero_b(nb), .codigo_op(cop), .executar_operacao(exec),
        .ocupado(ocup), .resultado_valido(val), .erro_timeout(err)
    );

    always #5 clk = ~clk;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] expv);
        n_cmp++;
        if (act !== expv) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, expv);
        end
    endtask

    // Reference model: the filtered level flips when the last DEB synchronized
    // raw samples all differ from it; the ULA deadline is TO cycles after launch.
    logic [DEB:0] m_hist = '0;
    logic         m_filt = 1'b0, m_press = 1'b0;
    int           ph = 0, cyc = 0, deadline = 0;
    logic [W-1:0] e_a = '0, e_b = '0;
    logic [2:0]   e_op = '0;
    logic         e_exec = 1'b0, e_ocup = 1'b0, e_val = 1'b0, e_err = 1'b0;

    function automatic logic flip_now(input logic [DEB:0] h, input logic f);
        logic r;
        r = 1'b1;
        for (int j = 1; j <= DEB; j++) if (h[j] == f) r = 1'b0;
        return r;
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_hist <= '0; m_filt <= 1'b0; m_press <= 1'b0; ph <= 0; cyc <= 0;
            e_a <= '0; e_b <= '0; e_op <= '0;
            e_exec <= 1'b0; e_ocup <= 1'b0; e_val <= 1'b0; e_err <= 1'b0;
        end else begin
            m_hist  <= {m_hist[DEB-1:0], botao};
            m_press <= flip_now(m_hist, m_filt) && !m_filt;
            if (flip_now(m_hist, m_filt)) m_filt <= ~m_filt;
            cyc    <= cyc + 1;
            e_exec <= 1'b0;
            case (ph)
                0: if (m_press) begin e_a <= num; ph <= 1; end
                1: if (m_press) begin e_b <= num; ph <= 2; end
                2: if (m_press) begin e_op <= op; ph <= 3; end
                3: if (m_press) begin e_exec <= 1'b1; e_ocup <= 1'b1; deadline <= cyc + TO; ph <= 4; end
                4: if (pronto) begin e_val <= 1'b1; e_ocup <= 1'b0; ph <= 5; end
                   else if (cyc == deadline) begin e_err <= 1'b1; e_ocup <= 1'b0; ph <= 5; end
                5: if (m_press) begin e_val <= 1'b0; e_err <= 1'b0; ph <= 0; end
                default: ph <= 0;
            endcase
        end
    end

    // Per-cycle comparison of every output against the model.
    always @(negedge clk) begin
        check("outputs", {7'd0, contador, na, nb, cop, exec, ocup, val, err},
              {7'd0, (ph < 4) ? ph[1:0] : 2'b11, e_a, e_b, e_op, e_exec, e_ocup, e_val, e_err});
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    // Plays a 40-tick button pattern; reports first contador change, launch tick,
    // error tick and number of launch pulses observed.
    task automatic play(input logic [39:0] pat, input logic [W-1:0] n, input logic [2:0] o,
                        input int pd, input int rst_at,
                        output int lat, output int e_i, output int err_i, output int n_exec);
        logic [1:0] c0;
        c0 = contador; lat = 0; e_i = 0; err_i = 0; n_exec = 0;
        num = n; op = o;
        for (int i = 0; i < 40; i++) begin
            botao = pat[i];
            if (i == rst_at) begin
                rst_n = 1'b0;
                #1;
                check("reset_contador", {30'd0, contador}, 32'd0);
                check("reset_ocupado", {31'd0, ocup}, 32'd0);
            end
            if (i == rst_at + 2) rst_n = 1'b1;
            tick();
            pronto = (pd >= 0 && e_i > 0 && i + 1 == e_i + pd);
            if (lat == 0 && contador != c0) lat = i + 1;
            if (exec) begin n_exec++; if (e_i == 0) e_i = i + 1; end
            if (err && err_i == 0) err_i = i + 1;
        end
        pronto = 1'b0;
    endtask

    localparam logic [39:0] P_PRESS  = 40'h00000000FF;
    localparam logic [39:0] P_TWICE  = 40'h00000FF0FF;
    localparam logic [39:0] P_TOGGLE = 40'h0000000FD5;
    localparam logic [39:0] P_GLITCH = 40'h0000000007;

    initial begin
        int lat, e_i, err_i, nx;
        #1 rst_n = 1'b0;
        repeat (3) tick();
        check("rst_contador", {30'd0, contador}, 32'd0);
        check("rst_flags", {28'd0, exec, ocup, val, err}, 32'd0);
        check("rst_operands", {13'd0, na, nb, cop}, 32'd0);
        rst_n = 1'b1;
        repeat (10) tick();
        check("idle_contador", {30'd0, contador}, 32'd0);

        // Full pass with a result three cycles after launch.
        play(P_PRESS, 8'h2A, 3'b000, -1, -1, lat, e_i, err_i, nx);
        check("press_latency", lat, 32'd7);
        check("contador_b", {30'd0, contador}, 32'd1);
        play(P_PRESS, 8'h15, 3'b000, -1, -1, lat, e_i, err_i, nx);
        check("contador_op", {30'd0, contador}, 32'd2);
        play(P_PRESS, 8'h00, 3'b001, -1, -1, lat, e_i, err_i, nx);
        check("contador_exec", {30'd0, contador}, 32'd3);
        play(P_PRESS, 8'h77, 3'b110, 3, -1, lat, e_i, err_i, nx);
        check("captured", {13'd0, na, nb, cop}, {13'd0, 8'h2A, 8'h15, 3'b001});
        check("one_exec", nx, 32'd1);
        check("valid_set", {29'd0, ocup, val, err}, 32'b010);
        play(P_PRESS, 8'h00, 3'b000, -1, -1, lat, e_i, err_i, nx);
        check("ack", {29'd0, contador, val}, 32'b000);
        check("hold_a", {24'd0, na}, 32'h2A);

        // Bouncy press and short glitch.
        play(P_TOGGLE, 8'h11, 3'b000, -1, -1, lat, e_i, err_i, nx);
        check("toggle_one_press", {30'd0, contador}, 32'd1);
        play(P_GLITCH, 8'h22, 3'b000, -1, -1, lat, e_i, err_i, nx);
        check("glitch_ignored", {30'd0, contador}, 32'd1);

        // Timeout, with extra presses during the wait.
        play(P_PRESS, 8'h33, 3'b000, -1, -1, lat, e_i, err_i, nx);
        play(P_PRESS, 8'h00, 3'b010, -1, -1, lat, e_i, err_i, nx);
        play(P_TWICE, 8'h00, 3'b000, -1, -1, lat, e_i, err_i, nx);
        check("timeout_delay", err_i - e_i, 32'd16);
        check("timeout_flags", {28'd0, contador, val, ocup}, 32'b1100);
        check("wait_presses_ignored", nx, 32'd1);
        play(P_PRESS, 8'h00, 3'b000, -1, -1, lat, e_i, err_i, nx);
        check("timeout_ack", {29'd0, contador, err}, 32'd0);

        // Result in the terminal-count cycle wins.
        repeat (3) play(P_PRESS, 8'h44, 3'b011, -1, -1, lat, e_i, err_i, nx);
        play(P_PRESS, 8'h00, 3'b000, TO - 1, -1, lat, e_i, err_i, nx);
        check("terminal_pronto", {30'd0, val, err}, 32'b10);
        play(P_PRESS, 8'h00, 3'b000, -1, -1, lat, e_i, err_i, nx);

        // Reset while waiting; a later result must be ignored.
        repeat (3) play(P_PRESS, 8'h55, 3'b100, -1, -1, lat, e_i, err_i, nx);
        play(P_PRESS, 8'h00, 3'b000, 12, 10, lat, e_i, err_i, nx);
        check("abort_state", {28'd0, contador, ocup, val}, 32'd0);
        check("abort_operands", {13'd0, na, nb, cop}, 32'd0);

        // Random traffic.
        for (int s = 0; s < 300; s++) begin
            botao = 1'($urandom_range(0, 1));
            for (int k = $urandom_range(1, 10); k > 0; k--) begin
                num    = 8'($urandom);
                op     = 3'($urandom);
                pronto = ($urandom_range(0, 7) == 0);
                tick();
            end
        end
        pronto = 1'b0;
        botao  = 1'b0;
        repeat (5) tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end
endmodule
